// File: rtl/cla8_arbiter_if.sv
// Request/response bundle between the requesting datapath units and the
// shared-adder arbiter. The arbiter is the slave; requesters and the response
// consumer together form the master side.
interface cla8_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*8-1:0] req_a;
    logic [NREQ*8-1:0] req_b;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [7:0]        rsp_sum;
    logic              rsp_cout;
    logic              rsp_ready;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
    );
endinterface

// File: rtl/cla8_arbiter.sv
// Round-robin arbiter sharing one 8-bit carry-lookahead adder between NREQ
// requesters. Operands of the granted requester are registered in front of
// the adder, so the response is visible the cycle after acceptance and a
// new request can load in the same cycle the old response retires.
//
// state | meaning
// IDLE  | no response pending
// RESP  | response held on rsp_* (rsp_valid = 1)

// 8-bit adder built from two 4-bit lookahead groups.
module CLA8 (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       cin_i,
    output logic [7:0] sum_o,
    output logic       cout_o
);
    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;

    // Generate/propagate terms and flattened lookahead carries per nibble.
    always_comb begin
        g = a_i & b_i;
        p = a_i ^ b_i;
        c = '0;
        c[0] = cin_i;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        c[5] = g[4] | (p[4] & c[4]);
        c[6] = g[5] | (p[5] & g[4]) | (p[5] & p[4] & c[4]);
        c[7] = g[6] | (p[6] & g[5]) | (p[6] & p[5] & g[4])
             | (p[6] & p[5] & p[4] & c[4]);
        c[8] = g[7] | (p[7] & g[6]) | (p[7] & p[6] & g[5])
             | (p[7] & p[6] & p[5] & g[4])
             | (p[7] & p[6] & p[5] & p[4] & c[4]);
    end

    assign sum_o  = p ^ c[7:0];
    assign cout_o = c[8];
endmodule

module cla8_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    cla8_arbiter_if.slave     arb_if
);
    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [7:0]     opa_q, opa_d;
    logic [7:0]     opb_q, opb_d;

    logic [IDW-1:0] gnt;
    logic           any_valid;
    logic           acc;

    // Round-robin search: walk offsets from high to low so the smallest
    // offset from ptr_q that has a valid request is the one left in gnt.
    always_comb begin
        logic [IDW:0] idx_w;
        gnt   = '0;
        idx_w = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx_w = {1'b0, ptr_q} + (IDW + 1)'(k);
            if (idx_w >= (IDW + 1)'(NREQ)) begin
                idx_w = idx_w - (IDW + 1)'(NREQ);
            end
            if (arb_if.req_valid[idx_w[IDW-1:0]]) begin
                gnt = idx_w[IDW-1:0];
            end
        end
    end

    assign any_valid = |arb_if.req_valid;
    assign acc       = ((state_q == IDLE) || arb_if.rsp_ready) && any_valid && !rst;

    // One-hot ready for the granted requester, only when the accept happens.
    always_comb begin
        arb_if.req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            arb_if.req_ready[i] = acc && (gnt == IDW'(i));
        end
    end

    // Next values for operands, owner ID and pointer; only loaded on acc.
    always_comb begin
        logic [IDW:0] nxt_w;
        opa_d = arb_if.req_a[{gnt, 3'b000} +: 8];
        opb_d = arb_if.req_b[{gnt, 3'b000} +: 8];
        id_d  = gnt;
        nxt_w = {1'b0, gnt} + (IDW + 1)'(1);
        if (nxt_w == (IDW + 1)'(NREQ)) begin
            nxt_w = '0;
        end
        ptr_d = nxt_w[IDW-1:0];
    end

    // FSM next state: a new accept always lands in RESP; otherwise a
    // retiring response returns to IDLE and a stalled one holds.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (acc) state_d = RESP;
            RESP: begin
                if (acc) begin
                    state_d = RESP;
                end else if (arb_if.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any pending response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
        end else begin
            state_q <= state_d;
            if (acc) begin
                ptr_q <= ptr_d;
                id_q  <= id_d;
                opa_q <= opa_d;
                opb_q <= opb_d;
            end
        end
    end

    CLA8 u_cla8 (
        .a_i    (opa_q),
        .b_i    (opb_q),
        .cin_i  (1'b0),
        .sum_o  (arb_if.rsp_sum),
        .cout_o (arb_if.rsp_cout)
    );

    assign arb_if.rsp_valid = (state_q == RESP);
    assign arb_if.rsp_id    = id_q;
endmodule

// File: tb/tb_cla8_arbiter.sv
// Directed bench for cla8_arbiter: a reference model predicts each grant,
// pushes the expected response to a scoreboard queue on acceptance and pops
// it when the response handshake completes.
module tb_cla8_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [7:0]     sum;
        logic           cout;
    } rsp_t;

    logic clk;
    logic rst;

    cla8_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) arb_if ();

    cla8_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk    (clk),
        .rst    (rst),
        .arb_if (arb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    rsp_t sb[$];
    logic m_valid;
    int   m_ptr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
        arb_if.req_a[8*i +: 8] = a;
        arb_if.req_b[8*i +: 8] = b;
    endtask

    // One clock: check combinational outputs at negedge against the model,
    // then advance the model across the rising edge.
    task automatic cycle();
        int          g;
        int          idx;
        logic        acc;
        logic [3:0]  exp_rdy;
        logic [8:0]  full;
        rsp_t        e;
        @(negedge clk);
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (g < 0 && arb_if.req_valid[idx]) g = idx;
        end
        acc     = (!m_valid || arb_if.rsp_ready) && (g >= 0) && !rst;
        exp_rdy = acc ? 4'(1 << g) : 4'b0000;
        chk("req_ready", 32'(arb_if.req_ready), 32'(exp_rdy));
        chk("rsp_valid", 32'(arb_if.rsp_valid), 32'(m_valid));
        if (m_valid) begin
            if (sb.size() == 0) begin
                chk("sb_nonempty", 32'(0), 32'(1));
            end else begin
                e = sb[0];
                chk("rsp_id",   32'(arb_if.rsp_id),   32'(e.id));
                chk("rsp_sum",  32'(arb_if.rsp_sum),  32'(e.sum));
                chk("rsp_cout", 32'(arb_if.rsp_cout), 32'(e.cout));
            end
        end
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0;
            m_ptr   = 0;
            sb.delete();
        end else begin
            if (m_valid && arb_if.rsp_ready && sb.size() > 0) void'(sb.pop_front());
            if (acc) begin
                full    = {1'b0, arb_if.req_a[8*g +: 8]} + {1'b0, arb_if.req_b[8*g +: 8]};
                e.id    = IDW'(g);
                e.sum   = full[7:0];
                e.cout  = full[8];
                sb.push_back(e);
                m_ptr   = (g + 1) % NREQ;
                m_valid = 1'b1;
            end else if (arb_if.rsp_ready) begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    initial begin
        m_valid = 1'b0;
        m_ptr   = 0;
        rst     = 1'b1;
        arb_if.req_valid = 4'b1111;
        arb_if.rsp_ready = 1'b1;
        arb_if.req_a     = '0;
        arb_if.req_b     = '0;
        for (int i = 0; i < NREQ; i++) set_req(i, 8'(i * 16), 8'h05);

        // Reset: two cycles with everything valid.
        @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(arb_if.req_ready), 32'(0));
        chk("rst_rsp_sum",   32'(arb_if.rsp_sum),   32'(0));
        chk("rst_rsp_id",    32'(arb_if.rsp_id),    32'(0));
        cycle();
        rst = 1'b0;

        // First cycle after reset grants 0.
        cycle();
        arb_if.req_valid = 4'b0000;

        // Single op: requester 2, 0xFF + 0x01.
        set_req(2, 8'hFF, 8'h01);
        arb_if.req_valid = 4'b0100;
        cycle();
        arb_if.req_valid = 4'b0000;
        chk("single_valid", 32'(arb_if.rsp_valid), 32'(1));
        chk("single_id",    32'(arb_if.rsp_id),    32'(2));
        chk("single_sum",   32'(arb_if.rsp_sum),   32'(8'h00));
        chk("single_cout",  32'(arb_if.rsp_cout),  32'(1));
        cycle();
        cycle();

        // Move pointer back to 0 via requester 3, then round robin.
        arb_if.req_valid = 4'b1000;
        cycle();
        for (int i = 0; i < NREQ; i++) set_req(i, 8'(i * 16), 8'h05);
        arb_if.req_valid = 4'b1111;
        for (int n = 0; n < 5; n++) cycle();
        arb_if.req_valid = 4'b0000;
        cycle();
        cycle();

        // Backpressure: requester 1 0x80+0x80, then stall with requester 3 waiting.
        set_req(1, 8'h80, 8'h80);
        set_req(3, 8'h33, 8'h44);
        arb_if.req_valid = 4'b0010;
        cycle();
        arb_if.req_valid = 4'b1000;
        arb_if.rsp_ready = 1'b0;
        for (int n = 0; n < 3; n++) cycle();
        chk("bp_id",   32'(arb_if.rsp_id),   32'(1));
        chk("bp_sum",  32'(arb_if.rsp_sum),  32'(8'h00));
        chk("bp_cout", 32'(arb_if.rsp_cout), 32'(1));
        arb_if.rsp_ready = 1'b1;
        cycle();
        arb_if.req_valid = 4'b0000;
        chk("bp_next_id", 32'(arb_if.rsp_id), 32'(3));
        cycle();
        cycle();

        // Wrap: grant 2 (ptr->3), then only 0 valid, then all valid -> 1.
        arb_if.req_valid = 4'b0100;
        cycle();
        set_req(0, 8'h7F, 8'h01);
        arb_if.req_valid = 4'b0001;
        cycle();
        chk("wrap_id",   32'(arb_if.rsp_id),   32'(0));
        chk("wrap_sum",  32'(arb_if.rsp_sum),  32'(8'h80));
        chk("wrap_cout", 32'(arb_if.rsp_cout), 32'(0));
        arb_if.req_valid = 4'b1111;
        cycle();
        chk("wrap_next_id", 32'(arb_if.rsp_id), 32'(1));
        arb_if.req_valid = 4'b0000;
        cycle();
        cycle();

        // Reset mid-op: response pending with stall, pointer nonzero.
        arb_if.req_valid = 4'b0100;
        cycle();
        arb_if.req_valid = 4'b0000;
        arb_if.rsp_ready = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("midrst_valid", 32'(arb_if.rsp_valid), 32'(0));
        arb_if.rsp_ready = 1'b1;
        arb_if.req_valid = 4'b1111;
        cycle();
        chk("midrst_grant0", 32'(arb_if.rsp_id), 32'(0));
        arb_if.req_valid = 4'b0000;
        cycle();
        cycle();
        chk("sb_drained", 32'(sb.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
